// File: rtl/fetch_pkg.sv
// Shared defaults and the fetch-queue entry layout for the instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned FETCH_PC_W     = 16;
   localparam int unsigned FETCH_INSTR_W  = 16;
   localparam int unsigned FETCH_PC_INC   = 2;
   localparam int unsigned FETCH_RESET_PC = 0;
   localparam int unsigned FETCH_FQ_DEPTH = 4;

   typedef struct packed {
      logic [FETCH_INSTR_W-1:0] instr;
      logic [FETCH_PC_W-1:0]    pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_q_if.sv
// Fetch-stage bus: redirect/halt control, instruction memory port and decode handshake.
interface fetch_unit_q_if #(
   parameter int unsigned PC_W    = 16,
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned CNT_W   = 3
);
   logic               redirect;
   logic [PC_W-1:0]    redirect_pc;
   logic               halt;
   logic               imem_rd_en;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0]    out_pc;
   logic [PC_W-1:0]    out_seq_pc;
   logic [CNT_W-1:0]   fq_count;

   modport master (
      input  redirect, redirect_pc, halt, imem_rdata, out_ready,
      output imem_rd_en, imem_addr, out_valid, out_instr, out_pc, out_seq_pc, fq_count
   );

   modport slave (
      output redirect, redirect_pc, halt, imem_rdata, out_ready,
      input  imem_rd_en, imem_addr, out_valid, out_instr, out_pc, out_seq_pc, fq_count
   );
endinterface

// File: rtl/fetch_unit_q_fifo.sv
// Synchronous FIFO with occupancy count; flush empties it and dominates a same-cycle push.
module fetch_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [WIDTH-1:0]           head_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_eff_c;

   // Pointer and count update; DEPTH is a power of two so pointers wrap naturally.
   always_comb begin
      push_eff_c = push_i && !flush_i;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_eff_c) mem_q[wr_ptr_q] <= data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit_q.sv
// Instruction-fetch stage: PC register, credit-based issue to a 1-cycle memory,
// fetch queue of {instr, pc} entries presented to decode over valid/ready.
module fetch_unit_q
   import fetch_pkg::*;
#(
   parameter int unsigned    PC_W     = FETCH_PC_W,
   parameter int unsigned    INSTR_W  = FETCH_INSTR_W,
   parameter int unsigned    PC_INC   = FETCH_PC_INC,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(FETCH_RESET_PC),
   parameter int unsigned    FQ_DEPTH = FETCH_FQ_DEPTH
) (
   input  logic            clk,
   input  logic            rst,
   fetch_unit_q_if.master  bus
);
   localparam int unsigned CNT_W   = $clog2(FQ_DEPTH) + 1;
   localparam int unsigned OCC_W   = CNT_W + 1;
   localparam int unsigned ENTRY_W = INSTR_W + PC_W;

   logic [PC_W-1:0]    pc_q, pc_d;
   logic               inflight_q, inflight_d;
   logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
   logic [CNT_W-1:0]   fq_count;
   logic [ENTRY_W-1:0] head;
   logic [OCC_W-1:0]   occ_c;
   logic               credit_c;
   logic               issue_c;
   logic               out_valid_c;
   logic               pop_c;

   // Credit counts the in-flight fetch, so a returning response always finds a free slot.
   assign occ_c    = OCC_W'(fq_count) + OCC_W'(inflight_q);
   assign credit_c = occ_c < OCC_W'(FQ_DEPTH);

   always_comb begin
      issue_c       = !rst && !bus.redirect && !bus.halt && credit_c;
      pc_d          = pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      if (bus.redirect) begin
         pc_d = bus.redirect_pc;
      end else if (issue_c) begin
         pc_d          = pc_q + PC_W'(PC_INC);
         inflight_d    = 1'b1;
         inflight_pc_d = pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= RESET_PC;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   assign out_valid_c = fq_count != '0;
   assign pop_c       = out_valid_c && bus.out_ready;

   // Redirect flushes the queue; the flush also drops a response landing that cycle.
   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FQ_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (inflight_q),
      .data_i  ({bus.imem_rdata, inflight_pc_q}),
      .pop_i   (pop_c),
      .flush_i (bus.redirect),
      .head_o  (head),
      .count_o (fq_count)
   );

   assign bus.imem_rd_en = issue_c;
   assign bus.imem_addr  = pc_q;
   assign bus.out_valid  = out_valid_c;
   assign bus.out_instr  = head[ENTRY_W-1:PC_W];
   assign bus.out_pc     = head[PC_W-1:0];
   assign bus.out_seq_pc = head[PC_W-1:0] + PC_W'(PC_INC);
   assign bus.fq_count   = fq_count;

endmodule

// File: tb/tb_fetch_unit_q.sv
// Directed bench for fetch_unit_q: memory returns ~addr; a scoreboard checks every accepted head.
module tb_fetch_unit_q;
   import fetch_pkg::*;

   localparam int unsigned PC_W    = 16;
   localparam int unsigned INSTR_W = 16;
   localparam int unsigned CNT_W   = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_unit_q_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus();

   fetch_unit_q #(
      .PC_W     (PC_W),
      .INSTR_W  (INSTR_W),
      .PC_INC   (2),
      .RESET_PC (16'h0000),
      .FQ_DEPTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   fetch_entry_t exp_q[$];

   // One-cycle-latency instruction memory; each word is the bitwise inverse of its address.
   always @(posedge clk) begin
      if (bus.imem_rd_en) bus.imem_rdata <= ~bus.imem_addr;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_pc(input logic [15:0] pc);
      fetch_entry_t e;
      e.pc    = pc;
      e.instr = ~pc;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted head must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         fetch_entry_t e;
         logic [15:0]  seq;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_unexpected: got pc 0x%0h, required no output", bus.out_pc);
         end else begin
            e   = exp_q.pop_front();
            seq = e.pc + 16'd2;
            if (bus.out_pc !== e.pc || bus.out_instr !== e.instr || bus.out_seq_pc !== seq) begin
               n_fail++;
               $display("FAIL pop_entry: got pc/instr/seq 0x%0h/0x%0h/0x%0h, required 0x%0h/0x%0h/0x%0h",
                        bus.out_pc, bus.out_instr, bus.out_seq_pc, e.pc, e.instr, seq);
            end
         end
      end
   end

   initial begin
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.halt        = 1'b0;
      bus.out_ready   = 1'b0;
      rst             = 1'b1;
      tick(); tick();
      check("rst_valid", 32'(bus.out_valid), 0);
      check("rst_count", 32'(bus.fq_count), 0);
      check("rst_rd_en", 32'(bus.imem_rd_en), 0);

      // T1: streaming from reset, one fetch per cycle, head valid two cycles after issue
      for (int p = 0; p < 12; p += 2) expect_pc(16'(p));
      tick(); rst = 1'b0; bus.out_ready = 1'b1; #1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin tick(); #1; end
         check("t1_rd_en", 32'(bus.imem_rd_en), 1);
         check("t1_addr", 32'(bus.imem_addr), 32'(2 * i));
         if (i < 2) check("t1_valid_early", 32'(bus.out_valid), 0);
         else begin
            check("t1_valid", 32'(bus.out_valid), 1);
            check("t1_out_pc", 32'(bus.out_pc), 32'(2 * (i - 2)));
         end
      end
      tick(); bus.halt = 1'b1; #1;
      check("t1_halt_rd_en", 32'(bus.imem_rd_en), 0);
      repeat (4) tick(); #1;
      check("t1_drained", 32'(bus.fq_count), 0);

      // T2: decode stalled from reset; credit limits issue to four fetches
      tick(); rst = 1'b1; bus.halt = 1'b0; bus.out_ready = 1'b0;
      tick(); rst = 1'b0; #1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin tick(); #1; end
         check("t2_rd_en", 32'(bus.imem_rd_en), 1);
         check("t2_addr", 32'(bus.imem_addr), 32'(2 * i));
      end
      tick(); #1;
      check("t2_no_credit", 32'(bus.imem_rd_en), 0);
      for (int p = 0; p < 10; p += 2) expect_pc(16'(p));
      tick(); bus.out_ready = 1'b1; #1;
      check("t2_full_rd_en", 32'(bus.imem_rd_en), 0);
      check("t2_full_count", 32'(bus.fq_count), 4);
      tick(); #1;
      check("t2_resume_rd_en", 32'(bus.imem_rd_en), 1);
      check("t2_resume_addr", 32'(bus.imem_addr), 32'h8);
      tick(); bus.halt = 1'b1; #1;
      check("t2_halt_rd_en", 32'(bus.imem_rd_en), 0);
      repeat (6) tick(); #1;
      check("t2_drained", 32'(bus.fq_count), 0);

      // T3: redirect with two queued entries and one fetch in flight
      tick(); bus.out_ready = 1'b0; bus.halt = 1'b0; #1;
      check("t3_addr0", 32'(bus.imem_addr), 32'hA);
      tick(); #1;
      check("t3_addr1", 32'(bus.imem_addr), 32'hC);
      tick(); #1;
      check("t3_addr2", 32'(bus.imem_addr), 32'hE);
      tick(); bus.redirect = 1'b1; bus.redirect_pc = 16'h0100; #1;
      check("t3_pre_count", 32'(bus.fq_count), 2);
      check("t3_redir_rd_en", 32'(bus.imem_rd_en), 0);
      expect_pc(16'h0100);
      tick(); bus.redirect = 1'b0; bus.out_ready = 1'b1; #1;
      check("t3_flush_count", 32'(bus.fq_count), 0);
      check("t3_flush_valid", 32'(bus.out_valid), 0);
      check("t3_target_rd_en", 32'(bus.imem_rd_en), 1);
      check("t3_target_addr", 32'(bus.imem_addr), 32'h100);
      tick(); bus.halt = 1'b1; #1;
      check("t3_stale_dropped", 32'(bus.fq_count), 0);
      tick(); #1;
      check("t3_n3_valid", 32'(bus.out_valid), 1);
      check("t3_n3_pc", 32'(bus.out_pc), 32'h100);
      tick(); #1;
      check("t3_drained", 32'(bus.fq_count), 0);

      // T4: halt with one fetch in flight; it still lands and fetch resumes at the held pc
      tick(); bus.out_ready = 1'b0; bus.halt = 1'b0; #1;
      check("t4_addr", 32'(bus.imem_addr), 32'h102);
      tick(); bus.halt = 1'b1; #1;
      check("t4_halt_rd_en0", 32'(bus.imem_rd_en), 0);
      tick(); #1;
      check("t4_halt_rd_en1", 32'(bus.imem_rd_en), 0);
      check("t4_landed", 32'(bus.fq_count), 1);
      tick(); #1;
      check("t4_halt_rd_en2", 32'(bus.imem_rd_en), 0);
      tick(); bus.halt = 1'b0; #1;
      check("t4_resume_rd_en", 32'(bus.imem_rd_en), 1);
      check("t4_resume_addr", 32'(bus.imem_addr), 32'h104);
      expect_pc(16'h0102);
      expect_pc(16'h0104);
      tick(); bus.halt = 1'b1; bus.out_ready = 1'b1; #1;
      check("t4_halt_again", 32'(bus.imem_rd_en), 0);
      repeat (4) tick(); #1;
      check("t4_drained", 32'(bus.fq_count), 0);

      // T5: PC wrap at the top of the address space
      expect_pc(16'hFFFE);
      expect_pc(16'h0000);
      tick(); bus.halt = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFE; #1;
      check("t5_redir_rd_en", 32'(bus.imem_rd_en), 0);
      tick(); bus.redirect = 1'b0; #1;
      check("t5_addr_top", 32'(bus.imem_addr), 32'hFFFE);
      tick(); #1;
      check("t5_addr_wrap", 32'(bus.imem_addr), 32'h0000);
      tick(); bus.halt = 1'b1; #1;
      check("t5_head_pc", 32'(bus.out_pc), 32'hFFFE);
      check("t5_head_seq", 32'(bus.out_seq_pc), 32'h0000);
      repeat (4) tick(); #1;
      check("t5_drained", 32'(bus.fq_count), 0);

      // T6: reset with three entries queued and one in flight
      tick(); bus.out_ready = 1'b0; bus.halt = 1'b0; #1;
      check("t6_addr0", 32'(bus.imem_addr), 32'h2);
      tick(); #1;
      tick(); #1;
      tick(); #1;
      check("t6_addr3", 32'(bus.imem_addr), 32'h8);
      tick(); rst = 1'b1; #1;
      check("t6_pre_count", 32'(bus.fq_count), 3);
      check("t6_rst_rd_en", 32'(bus.imem_rd_en), 0);
      tick(); #1;
      check("t6_rst_count", 32'(bus.fq_count), 0);
      check("t6_rst_valid", 32'(bus.out_valid), 0);
      expect_pc(16'h0000);
      tick(); rst = 1'b0; bus.out_ready = 1'b1; #1;
      check("t6_restart_rd_en", 32'(bus.imem_rd_en), 1);
      check("t6_restart_addr", 32'(bus.imem_addr), 32'h0);
      tick(); bus.halt = 1'b1; #1;
      repeat (4) tick(); #1;
      check("t6_drained", 32'(bus.fq_count), 0);

      check("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
